// File: rtl/gpu_mem_pkg.sv
// Shared SRAM map, default geometry and streamer state encoding for the GPU memory clients.
package gpu_mem_pkg;

    // SRAM map (word addresses)
    localparam int LAYER1_BASE  = 0;
    localparam int LAYER2_BASE  = 65536;
    localparam int TEX1_BASE    = 131072;
    localparam int TEX2_BASE    = 135168;
    localparam int TEX3_BASE    = 139264;
    localparam int OUTBUF_BASE  = 143360;
    // Output buffer length in words
    localparam int OUTBUF_WORDS = 65536;

    // Default SRAM geometry
    localparam int DEF_ADDR_SIZE_BITS  = 24;
    localparam int DEF_WORD_SIZE_BYTES = 3;
    localparam int DEF_DATA_SIZE_WORDS = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_CAPTURE,
        ST_SHIFT,
        ST_UPDATE,
        ST_DONE
    } stream_state_t;

    // Counter width that stays at least one bit wide for tiny depths
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pixel_shift_buffer.sv
// Holds one SRAM burst and presents its words one at a time, word 0 first.
module pixel_shift_buffer
    import gpu_mem_pkg::*;
#(
    parameter int WORD_BITS       = 24,
    parameter int DATA_SIZE_WORDS = 64
)(
    input  logic                                 clk,
    input  logic                                 n_rst,
    input  logic                                 load,
    input  logic                                 advance,
    input  logic [DATA_SIZE_WORDS*WORD_BITS-1:0] read_data,
    output logic [WORD_BITS-1:0]                 word,
    output logic                                 last
);
    localparam int CNT_W = clog2_min1(DATA_SIZE_WORDS);

    logic [DATA_SIZE_WORDS-1:0][WORD_BITS-1:0] burst;
    logic [CNT_W-1:0]                          word_cnt;

    // Capture a burst on load; step the word index on each accepted transfer
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            burst    <= '0;
            word_cnt <= '0;
        end else if (load) begin
            burst    <= read_data;
            word_cnt <= '0;
        end else if (advance && !last) begin
            word_cnt <= word_cnt + 1'b1;
        end
    end

    assign last = (word_cnt == CNT_W'(DATA_SIZE_WORDS - 1));
    assign word = burst[word_cnt];

endmodule

// File: rtl/output_streamer.sv
// Reads the blended output buffer burst by burst and streams it as pixels.
// Optional running checksum enabled by defining OUTPUT_STREAMER_CHECKSUM_EN.
module output_streamer
    import gpu_mem_pkg::*;
#(
    parameter int ADDR_SIZE_BITS  = DEF_ADDR_SIZE_BITS,
    parameter int WORD_SIZE_BYTES = DEF_WORD_SIZE_BYTES,
    parameter int DATA_SIZE_WORDS = DEF_DATA_SIZE_WORDS,
    parameter int BASE_ADDR       = OUTBUF_BASE,
    parameter int BUF_WORDS       = OUTBUF_WORDS
)(
    input  logic                                       clk,
    input  logic                                       n_rst,
    input  logic                                       stream_en,
    output logic                                       stream_done,
    output logic                                       busy,
    output logic                                       read_enable,
    output logic                                       write_enable,
    output logic [ADDR_SIZE_BITS-1:0]                  address,
    input  logic [WORD_SIZE_BYTES*DATA_SIZE_WORDS*8-1:0] read_data,
    output logic [WORD_SIZE_BYTES*8-1:0]               pixel_data,
    output logic                                       pixel_valid,
    input  logic                                       pixel_ready,
    output logic [WORD_SIZE_BYTES*8-1:0]               checksum
);
    localparam int WORD_BITS = WORD_SIZE_BYTES * 8;
    // Wide enough to hold BUF_WORDS itself so the end compare never sees a wrap
    localparam int OFF_W     = $clog2(BUF_WORDS + 1);

    stream_state_t        state, state_nxt;
    logic [OFF_W-1:0]     offset;
    logic                 buf_end;
    logic                 rd_active;
    logic                 load, advance, last;
    logic [WORD_BITS-1:0] word;

    assign buf_end = (offset == OFF_W'(BUF_WORDS));

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Buffer offset: advance per burst, rewind once the buffer is finished
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)                  offset <= '0;
        else if (state == ST_UPDATE) offset <= offset + OFF_W'(DATA_SIZE_WORDS);
        else if (state == ST_DONE)   offset <= '0;
    end

    // Next state and per-state strobes
    always_comb begin
        state_nxt   = state;
        busy        = 1'b1;
        rd_active   = 1'b0;
        load        = 1'b0;
        advance     = 1'b0;
        pixel_valid = 1'b0;
        stream_done = 1'b0;
        unique case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (stream_en) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (buf_end) begin
                    state_nxt = ST_DONE;
                end else begin
                    rd_active = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // second strobe cycle, same address
                rd_active = 1'b1;
                state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                load      = 1'b1;
                state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                pixel_valid = 1'b1;
                if (pixel_ready) begin
                    advance = 1'b1;
                    if (last) state_nxt = ST_UPDATE;
                end
            end
            ST_UPDATE: state_nxt = ST_REQ;
            ST_DONE: begin
                stream_done = 1'b1;
                state_nxt   = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign read_enable  = rd_active;
    assign write_enable = 1'b0;
    assign address      = rd_active ? (ADDR_SIZE_BITS'(BASE_ADDR) + ADDR_SIZE_BITS'(offset))
                                    : '0;
    assign pixel_data   = pixel_valid ? word : '0;

    pixel_shift_buffer #(
        .WORD_BITS       (WORD_BITS),
        .DATA_SIZE_WORDS (DATA_SIZE_WORDS)
    ) u_shift (
        .clk       (clk),
        .n_rst     (n_rst),
        .load      (load),
        .advance   (advance),
        .read_data (read_data),
        .word      (word),
        .last      (last)
    );

`ifdef OUTPUT_STREAMER_CHECKSUM_EN
    logic [WORD_BITS-1:0] csum;

    // Running sum of accepted pixels, restarted when a new stream begins
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)                           csum <= '0;
        else if (state == ST_IDLE && stream_en) csum <= '0;
        else if (advance)                     csum <= csum + pixel_data;
    end

    assign checksum = csum;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_output_streamer.sv
// Scoreboard bench for output_streamer, run with a reduced buffer length.
module tb_output_streamer;
    import gpu_mem_pkg::*;

    localparam int AW    = 24;
    localparam int DW    = 64;
    localparam int BASE  = 143360;
    localparam int BUFW  = 512;
    localparam int NB    = BUFW / DW;
`ifdef OUTPUT_STREAMER_CHECKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            n_rst = 1'b0;
    logic            stream_en = 1'b0;
    logic            stream_done, busy, read_enable, write_enable;
    logic [AW-1:0]   address;
    logic [DW*24-1:0] read_data;
    logic [23:0]     pixel_data;
    logic            pixel_valid;
    logic            pixel_ready = 1'b1;
    logic [23:0]     checksum;

    always #5 clk = ~clk;

    output_streamer #(
        .BUF_WORDS (BUFW)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .stream_en    (stream_en),
        .stream_done  (stream_done),
        .busy         (busy),
        .read_enable  (read_enable),
        .write_enable (write_enable),
        .address      (address),
        .read_data    (read_data),
        .pixel_data   (pixel_data),
        .pixel_valid  (pixel_valid),
        .pixel_ready  (pixel_ready),
        .checksum     (checksum)
    );

    // SRAM model: latch the strobed address, return that burst's pattern
    logic          ones_mode = 1'b0;
    logic [AW-1:0] lat_addr = '0;
    logic [23:0]   burst_k;
    logic [DW-1:0][23:0] rd_words;

    always @(posedge clk) if (read_enable) lat_addr <= address;
    assign burst_k = (lat_addr - 24'(BASE)) >> 6;
    always_comb begin
        rd_words = '0;
        for (int w = 0; w < DW; w++)
            rd_words[w] = ones_mode ? 24'h000001 : {burst_k[7:0], 8'(w), 8'hA5};
    end
    assign read_data = rd_words;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] addr_q[$];
    logic        prev_valid = 1'b0;
    logic [23:0] prev_data = '0;
    logic        prev_re = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    int          re_len = 0;
    int          acc_cnt = 0;
    int          done_cnt = 0;
    logic [23:0] cs_model = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; monitors transfers, strobes and done at the falling edge
    task automatic tick();
        logic [31:0] e;
        @(posedge clk);
        @(negedge clk);
        chk("write_enable", {31'd0, write_enable}, 32'd0);
        if (prev_valid && pixel_ready) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else                  e = 32'hDEADBEEF;
            chk("pixel", {8'd0, prev_data}, e);
            cs_model = cs_model + prev_data;
            acc_cnt++;
        end
        if (prev_valid && !pixel_ready) begin
            chk("hold_valid", {31'd0, pixel_valid}, 32'd1);
            chk("hold_data", {8'd0, pixel_data}, {8'd0, prev_data});
        end
        if (read_enable && !prev_re) begin
            if (addr_q.size() > 0) e = addr_q.pop_front();
            else                   e = 32'hFFFFFFFF;
            chk("addr", {8'd0, address}, e);
            re_len = 1;
        end else if (read_enable && prev_re) begin
            chk("addr_hold", {8'd0, address}, {8'd0, prev_addr});
            re_len++;
        end else if (!read_enable && prev_re) begin
            chk("re_len", re_len, 2);
        end
        if (!read_enable) chk("addr_idle", {8'd0, address}, 32'd0);
        if (stream_done) done_cnt++;
        prev_valid = pixel_valid;
        prev_data  = pixel_data;
        prev_re    = read_enable;
        prev_addr  = address;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"},  {31'd0, busy},         32'd0);
        chk({tag, "_done"},  {31'd0, stream_done},  32'd0);
        chk({tag, "_re"},    {31'd0, read_enable},  32'd0);
        chk({tag, "_we"},    {31'd0, write_enable}, 32'd0);
        chk({tag, "_addr"},  {8'd0, address},       32'd0);
        chk({tag, "_data"},  {8'd0, pixel_data},    32'd0);
        chk({tag, "_valid"}, {31'd0, pixel_valid},  32'd0);
        chk({tag, "_csum"},  {8'd0, checksum},      32'd0);
    endtask

    // Start a stream; optional stall (5 cycles at accept index), stream_en poke, reset abort
    task automatic run_stream(input bit ones, input int stall_at, input int poke_at,
                              input int abort_at, output int done_t, output int first_t);
        int stall_left;
        ones_mode = ones;
        exp_q.delete();
        addr_q.delete();
        for (int k = 0; k < NB; k++) begin
            addr_q.push_back(32'(BASE + k * DW));
            for (int w = 0; w < DW; w++)
                exp_q.push_back(ones ? 32'h1 : {8'd0, 8'(k), 8'(w), 8'hA5});
        end
        cs_model   = '0;
        acc_cnt    = 0;
        done_cnt   = 0;
        done_t     = -1;
        first_t    = -1;
        stall_left = 5;
        pixel_ready = 1'b1;
        stream_en  = 1'b1;
        for (int t = 1; t <= 2000; t++) begin
            tick();
            stream_en = 1'b0;
            if (pixel_valid && first_t < 0) first_t = t;
            if (stream_done) begin
                done_t = t;
                break;
            end
            if (abort_at >= 0 && acc_cnt == abort_at) begin
                n_rst = 1'b0;
                #1;
                check_zero("abort");
                done_t = -2;
                break;
            end
            pixel_ready = 1'b1;
            if (acc_cnt == stall_at && stall_left > 0 && pixel_valid) begin
                pixel_ready = 1'b0;
                stall_left--;
            end
            if (acc_cnt == poke_at && pixel_valid) stream_en = 1'b1;
        end
        pixel_ready = 1'b1;
        stream_en   = 1'b0;
        if (abort_at < 0) chk("done_seen", {31'd0, done_t > 0}, 32'd1);
    endtask

    // Checks common to every stream that ran to completion
    task automatic post_checks(input string tag, input int done_t, input int exp_t);
        chk({tag, "_done_t"},  done_t, exp_t);
        chk({tag, "_exp_q"},   exp_q.size(), 0);
        chk({tag, "_addr_q"},  addr_q.size(), 0);
        chk({tag, "_csum"},    {8'd0, checksum}, CS_EN ? {8'd0, cs_model} : 32'd0);
        tick();
        tick();
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_idle"},     {31'd0, busy}, 32'd0);
        chk({tag, "_csum_hold"}, {8'd0, checksum}, CS_EN ? {8'd0, cs_model} : 32'd0);
    endtask

    initial begin
        int done_t, first_t;

        // Reset state
        repeat (2) tick();
        check_zero("reset");
        n_rst = 1'b1;
        tick();
        check_zero("post_reset");

        // Plain stream, ready held high: latency, data, addresses, total time
        run_stream(1'b0, -1, -1, -1, done_t, first_t);
        chk("first_valid_t", first_t, 4);
        post_checks("plain", done_t, NB * 68 + 2);

        // Backpressure at word 10 of burst 1 plus a stream_en during SHIFT
        run_stream(1'b0, DW + 10, 200, -1, done_t, first_t);
        post_checks("stall", done_t, NB * 68 + 2 + 5);

        // All-ones pixels: checksum counts pixels when enabled
        run_stream(1'b1, -1, -1, -1, done_t, first_t);
        chk("ones_csum", {8'd0, checksum}, CS_EN ? 32'(BUFW) : 32'd0);
        post_checks("ones", done_t, NB * 68 + 2);

        // Reset during burst 3, then a clean restart from the buffer base
        run_stream(1'b0, -1, -1, 3 * DW + 5, done_t, first_t);
        prev_valid = 1'b0;
        prev_re    = 1'b0;
        done_cnt   = 0;
        tick();
        check_zero("in_reset");
        chk("abort_no_done", done_cnt, 0);
        n_rst = 1'b1;
        tick();
        run_stream(1'b0, -1, -1, -1, done_t, first_t);
        chk("restart_first_valid_t", first_t, 4);
        post_checks("restart", done_t, NB * 68 + 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
